// File: rtl/cic_comp_pkg.sv
// Shared types and constants for the CIC droop-compensation FIR.
package cic_comp_pkg;

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    localparam int COEF_WIDTH_DEF = 8;
    localparam int FRAC_DEF       = 6;

    localparam logic signed [7:0] COEFS3 [3] = '{-8'sd8, 8'sd80, -8'sd8};
    localparam logic signed [7:0] COEFS5 [5] = '{-8'sd4, -8'sd8, 8'sd88, -8'sd8, -8'sd4};

    // Accumulator is wide enough that a full sum of worst-case products cannot overflow.
    function automatic int acc_width(input int w, input int cw, input int taps);
        return w + cw + $clog2(taps) + 1;
    endfunction

endpackage

// File: rtl/cic_comp_sat.sv
// Round-half-up by FRAC bits, then clamp the signed accumulator into the unsigned output range.
module cic_comp_sat #(
    parameter int WIDTH = 8,
    parameter int FRAC  = 6,
    parameter int ACC_W = 19
) (
    input  logic signed [ACC_W-1:0] i_acc,
    output logic        [WIDTH-1:0] o_out
);

    localparam int                      HALF  = 1 << (FRAC - 1);
    localparam logic signed [ACC_W-1:0] W_MAX = ACC_W'((1 << WIDTH) - 1);

    logic signed [ACC_W-1:0] w_sum;
    logic signed [ACC_W-1:0] w_shift;

    assign w_sum   = i_acc + ACC_W'(HALF);
    assign w_shift = w_sum >>> FRAC;

    always_comb begin
        o_out = w_shift[WIDTH-1:0];
        if (w_shift[ACC_W-1]) begin
            o_out = '0;
        end else if (w_shift > W_MAX) begin
            o_out = '1;
        end
    end

endmodule

// File: rtl/cic_comp_fir.sv
// Symmetric compensation FIR at the decimated rate: one shared multiplier,
// one tap per cycle, rounded and saturated unsigned result.
module cic_comp_fir
    import cic_comp_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int TAPS       = 3,
    parameter int COEF_WIDTH = COEF_WIDTH_DEF,
    parameter int FRAC       = FRAC_DEF,
    parameter logic signed [COEF_WIDTH-1:0] COEFS [TAPS] = COEFS3
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             overrun
);

    localparam int ACC_W = acc_width(WIDTH, COEF_WIDTH, TAPS);
    localparam int IDX_W = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TAPS - 1);

    state_t                  r_state;
    state_t                  w_state_next;
    logic [WIDTH-1:0]        r_taps [TAPS];
    logic signed [ACC_W-1:0] r_acc;
    logic [IDX_W-1:0]        r_idx;

    logic                    w_accept;
    logic                    w_last;
    logic signed [COEF_WIDTH-1:0] w_coef;
    logic [WIDTH-1:0]        w_tap;
    logic signed [ACC_W-1:0] w_coef_ext;
    logic signed [ACC_W-1:0] w_tap_ext;
    logic signed [ACC_W-1:0] w_prod;
    logic [WIDTH-1:0]        w_sat;

    assign in_ready = (r_state == IDLE) || (r_state == DONE);
    assign w_accept = in_valid && in_ready;
    assign w_last   = (r_idx == LAST_IDX);

    // Taps are unsigned samples; zero-extend before the signed multiply.
    assign w_coef     = COEFS[r_idx];
    assign w_tap      = r_taps[r_idx];
    assign w_coef_ext = {{(ACC_W-COEF_WIDTH){w_coef[COEF_WIDTH-1]}}, w_coef};
    assign w_tap_ext  = {{(ACC_W-WIDTH){1'b0}}, w_tap};
    assign w_prod     = w_coef_ext * w_tap_ext;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_next = MAC;
            MAC:     if (w_last)   w_state_next = DONE;
            DONE:    w_state_next = w_accept ? MAC : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_taps[0] <= '0;
        end else if (w_accept) begin
            r_taps[0] <= in;
        end
    end

    genvar gi;
    generate
        for (gi = 1; gi < TAPS; gi++) begin : g_delay
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    r_taps[gi] <= '0;
                end else if (w_accept) begin
                    r_taps[gi] <= r_taps[gi-1];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_acc <= '0;
            r_idx <= '0;
        end else if (w_accept) begin
            r_acc <= '0;
            r_idx <= '0;
        end else if (r_state == MAC) begin
            r_acc <= r_acc + w_prod;
            if (!w_last) begin
                r_idx <= r_idx + IDX_W'(1);
            end
        end
    end

    cic_comp_sat #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC),
        .ACC_W (ACC_W)
    ) u_sat (
        .i_acc (r_acc),
        .o_out (w_sat)
    );

    // DONE overlaps the next accept, so the result is taken from acc before it clears.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out       <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            out_valid <= (r_state == DONE);
            if (r_state == DONE) begin
                out <= w_sat;
            end
            if (in_valid && !in_ready) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cic_comp_fir.sv
// Self-checking bench: a sample-level model predicts every output, plus literal result checks.
module tb_cic_comp_fir;

    localparam int WIDTH = 8;
    localparam int TAPS  = 3;
    localparam int FRAC  = 6;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic [WIDTH-1:0] in = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic             overrun;

    int n_checks = 0;
    int n_errors = 0;

    int coef [TAPS] = '{-8, 80, -8};

    // Model state (written only by the model process)
    int line [TAPS] = '{0, 0, 0};
    int cyc = 0;
    int last_acc = -100;
    int exp_ovr = 0;
    int due_q [$];
    int val_q [$];

    // Compare-side state
    int rd_ptr = 0;
    int exp_out = 0;
    int got [$];

    cic_comp_fir dut (
        .clk       (clk),
        .rstn      (rstn),
        .in        (in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (out),
        .out_valid (out_valid),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // FIR output from the filter definition: weighted sum, round half up, clamp.
    function automatic int fir_expect(input int l0, input int l1, input int l2);
        int s;
        int r;
        s = coef[0] * l0 + coef[1] * l1 + coef[2] * l2;
        r = (s + (1 << (FRAC - 1))) >>> FRAC;
        if (r < 0) r = 0;
        if (r > 255) r = 255;
        return r;
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            line = '{0, 0, 0};
            last_acc = cyc - 100;
            exp_ovr = 0;
            due_q.delete();
            val_q.delete();
        end else begin
            cyc++;
            if (in_valid) begin
                if (cyc - last_acc >= TAPS + 1) begin
                    line[2] = line[1];
                    line[1] = line[0];
                    line[0] = int'(in);
                    last_acc = cyc;
                    due_q.push_back(cyc + TAPS + 1);
                    val_q.push_back(fir_expect(line[0], line[1], line[2]));
                end else begin
                    exp_ovr = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rstn) begin
            rd_ptr = 0;
            exp_out = 0;
            chk("rst_out", int'(out), 0);
            chk("rst_out_valid", int'(out_valid), 0);
            chk("rst_overrun", int'(overrun), 0);
        end else begin
            if (rd_ptr < due_q.size() && due_q[rd_ptr] == cyc) begin
                chk("out_valid_pulse", int'(out_valid), 1);
                chk("out_value", int'(out), val_q[rd_ptr]);
                exp_out = val_q[rd_ptr];
                rd_ptr++;
            end else begin
                chk("out_valid_idle", int'(out_valid), 0);
                chk("out_hold", int'(out), exp_out);
            end
            chk("overrun", int'(overrun), exp_ovr);
            chk("in_ready", int'(in_ready), (cyc - last_acc >= TAPS) ? 1 : 0);
            if (out_valid) got.push_back(int'(out));
        end
    end

    // Called #1 after an edge; the sample is accepted on the next edge.
    task automatic send(input int v, input int wait_edges);
        in = v[WIDTH-1:0];
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in = WIDTH'($urandom);
        repeat (wait_edges) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_got(input string name, input int base, input int vals [$]);
        chk({name, "_count"}, got.size() - base, vals.size());
        foreach (vals[i]) begin
            if (base + i < got.size()) chk(name, got[base + i], vals[i]);
        end
    endtask

    initial begin
        int base;
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        // Model pins against hand-computed values
        chk("pin_dc1", fir_expect(100, 0, 0), 0);
        chk("pin_dc2", fir_expect(100, 100, 0), 113);
        chk("pin_dc3", fir_expect(100, 100, 100), 100);
        chk("pin_sat", fir_expect(255, 255, 0), 255);

        // 1: reset
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        #1;
        chk("ready_after_reset", int'(in_ready), 1);
        @(posedge clk);
        #1;

        // 2: DC 100, minimum period
        base = got.size();
        for (int i = 0; i < 5; i++) send(100, 3);
        repeat (6) @(posedge clk);
        #1;
        expect_got("dc", base, '{0, 113, 100, 100, 100});

        // 3: positive saturation
        do_reset();
        base = got.size();
        send(255, 3);
        send(255, 3);
        send(255, 8);
        expect_got("pos_sat", base, '{0, 255, 255});

        // 4: negative saturation
        do_reset();
        base = got.size();
        send(200, 8);
        expect_got("neg_sat", base, '{0});

        // 5: overrun; second sample dropped, line untouched by it
        do_reset();
        base = got.size();
        send(100, 3);
        send(100, 3);
        send(50, 0);
        send(77, 8);
        chk("overrun_sticky", int'(overrun), 1);
        send(90, 8);
        chk("overrun_still", int'(overrun), 1);
        expect_got("overrun", base, '{0, 113, 106, 39});

        // 6: reset one cycle after accept
        do_reset();
        send(100, 3);
        base = got.size();
        send(120, 0);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        chk("mid_reset_no_pulse", got.size() - base, 0);
        chk("mid_reset_out", int'(out), 0);
        send(64, 8);
        expect_got("after_mid_reset", base, '{0});

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
